reaction_timer: RTL
===================

# reaction_timer

Downstream stage of the reaction-time game's lights-out delay. It arms on the game FSM's start request and measures, in milliseconds, the interval from the lights-out pulse to the player's key press. It flags early (cheat) presses and tracks the best time since reset. Its 14-bit result feeds the binary-to-BCD converter and seven-segment display path in place of the raw PRBS value.

## Interface
Parameters:
- MAX_MS, 9999: saturation value for the measured time; fits in 14 bits and four BCD digits.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick_ms  in  1  one-cycle enable pulse, once per millisecond (from the 50000 divider).
- start  in  1  level or pulse from the game FSM requesting a new round (start_delay).
- go  in  1  one-cycle lights-out pulse from the delay block (time_out).
- key_n  in  1  raw, asynchronous, active-low player button (KEY[0]).
- react_ms  out  14  last captured reaction time, binary ms.
- best_ms  out  14  minimum valid reaction time since reset.
- result_valid  out  1  high while holding a valid, non-saturated result.
- cheat  out  1  high while holding a cheat result.
- overflow  out  1  high while holding a saturated (timeout) result.
- busy  out  1  high in ARMED or TIMING.

## Operation
- Key input:
  - 2-flop synchronizer on key_n, then a third flop for edge detection. All three flops reset to 1.
  - press = previous synchronized value 1 and current synchronized value 0. One-cycle pulse per falling edge.
  - Holding the key generates no further presses.
- States and transitions:
  - IDLE: on start, go to ARMED.
  - ARMED:
    - press goes to CHEAT, regardless of go in the same cycle; press wins.
    - Otherwise, go clears the counter to 0 and moves to TIMING.
  - TIMING: the counter increments on each tick_ms and saturates at MAX_MS.
    - press: go to DONE and latch react_ms = counter value after this cycle's tick is applied.
    - Counter reaches MAX_MS: go to DONE with overflow = 1 and react_ms = MAX_MS.
  - DONE and CHEAT: hold all outputs. start begins a new round (to ARMED).
- start is ignored in ARMED and TIMING. go is ignored outside ARMED.
- Result flags on entering DONE or CHEAT:
  - result_valid, cheat and overflow are mutually exclusive; all three clear on leaving the state.
  - Cheat: react_ms is left unchanged.
  - Valid result: best_ms updates to react_ms only if react_ms < best_ms; a tie makes no change.
  - Overflow or cheat: best_ms is never updated.
- A press with no tick in the same cycle captures the current counter value unchanged. A zero result is legal: press within the first ms after go gives 0.
- Reset: state IDLE, counter 0, react_ms 0, best_ms MAX_MS, result_valid 0, cheat 0, overflow 0, busy 0.
  - Reset mid-round aborts immediately, with no capture and no best update.

## Timing
- key_n falling edge to state change: the 3rd rising edge after key_n is first sampled low (2 sync stages plus the edge register). A response is therefore measured late by at most 3 cycles (60 ns), which is negligible against the 1 ms resolution.
- go registered in ARMED: TIMING entered, counter 0, on the next edge.
- All outputs are registered and change on the edge that performs the transition. busy rises on the edge entering ARMED.
- Counter resolution is 1 ms. The count is the number of tick_ms pulses seen in TIMING, up to and including the capture cycle.
- Throughput: one round per start; a new start is accepted the cycle after entering DONE or CHEAT.

## Test plan
- Normal round: start, go, 237 tick_ms pulses, then key_n low. Required: react_ms = 237, result_valid = 1, best_ms = 237, busy = 0, state change exactly 3 edges after key_n is sampled low.
- Best tracking: a second round of 412 ms, then a third of 150 ms. Required: best_ms stays 237, then becomes 150. react_ms reads 412, then 150.
- Cheat: press in ARMED before go, then a press in the same cycle as go. Both rounds: cheat = 1, react_ms and best_ms unchanged, go ignored afterwards.
- Overflow: go, then no press for 10000 ticks. Required: DONE at count 9999, overflow = 1, react_ms = 9999, best_ms unchanged. A later press is ignored.
- Edges: tick and press in the same cycle at count 41 gives react_ms = 42. Key held through start and go creates no press. start pulses during TIMING are ignored.
- Reset mid-TIMING at count 500: all outputs return to reset values (best_ms = 9999), state IDLE, and the next round measures correctly.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction-time measurement stage. Arms on start, times from the go pulse to
// the player's key press in millisecond ticks, flags early presses and keeps
// the best valid time since reset.
module reaction_timer #(
  parameter int unsigned MAX_MS = 9999
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tick_ms,
  input  logic        start,
  input  logic        go,
  input  logic        key_n,
  output logic [13:0] react_ms,
  output logic [13:0] best_ms,
  output logic        result_valid,
  output logic        cheat,
  output logic        overflow,
  output logic        busy
);

  localparam int unsigned W = 14;
  localparam logic [W-1:0] MAX_V = W'(MAX_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TIMING,
    S_DONE,
    S_CHEAT
  } state_t;

  state_t state;
  state_t state_nx;

  logic key_s1;
  logic key_s2;
  logic key_s3;
  logic press_c;

  logic [W-1:0] count;
  logic [W-1:0] count_nx;
  logic [W-1:0] count_inc_c;
  logic [W-1:0] react_nx;
  logic [W-1:0] best_nx;
  logic         valid_nx;
  logic         cheat_nx;
  logic         overflow_nx;
  logic         busy_nx;

  // Key synchronizer plus edge register; idle-high so reset never fakes a press
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  // One-cycle pulse on each synchronized falling edge of the button
  assign press_c = key_s3 & ~key_s2;

  // Counter value after this cycle's tick, saturating at MAX_MS
  always_comb begin
    count_inc_c = count;
    if (tick_ms) begin
      if (count >= MAX_V) begin
        count_inc_c = MAX_V;
      end else begin
        count_inc_c = count + W'(1);
      end
    end
  end

  // Next-state and next-output logic for the round sequencer
  always_comb begin
    state_nx    = state;
    count_nx    = count;
    react_nx    = react_ms;
    best_nx     = best_ms;
    valid_nx    = result_valid;
    cheat_nx    = cheat;
    overflow_nx = overflow;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        // An early press beats a simultaneous lights-out pulse
        if (press_c) begin
          state_nx = S_CHEAT;
          cheat_nx = 1'b1;
        end else if (go) begin
          state_nx = S_TIMING;
          count_nx = '0;
        end
      end
      S_TIMING: begin
        count_nx = count_inc_c;
        // A saturated count is a timeout even if the key lands on the same cycle
        if (count_inc_c == MAX_V) begin
          state_nx    = S_DONE;
          react_nx    = MAX_V;
          overflow_nx = 1'b1;
        end else if (press_c) begin
          state_nx = S_DONE;
          react_nx = count_inc_c;
          valid_nx = 1'b1;
          if (count_inc_c < best_ms) begin
            best_nx = count_inc_c;
          end
        end
      end
      S_DONE, S_CHEAT: begin
        if (start) begin
          state_nx    = S_ARMED;
          valid_nx    = 1'b0;
          cheat_nx    = 1'b0;
          overflow_nx = 1'b0;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx == S_ARMED) || (state_nx == S_TIMING);
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counter and registered result outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count        <= '0;
      react_ms     <= '0;
      best_ms      <= MAX_V;
      result_valid <= 1'b0;
      cheat        <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      count        <= count_nx;
      react_ms     <= react_nx;
      best_ms      <= best_nx;
      result_valid <= valid_nx;
      cheat        <= cheat_nx;
      overflow     <= overflow_nx;
      busy         <= busy_nx;
    end
  end

endmodule
